hack_memory_map: RTL and testbench

- Combinational address decoder and read-data multiplexer for the Hack data-memory space.
- Takes the CPU's 16-bit data address and write strobe, then:
  - generates one write-enable per target: the data RAM and sixteen memory-mapped IO registers IO0..IOF;
  - returns the read word of the selected target.
- Sits between the CPU data port and the RAM/peripheral blocks.
- Holds no storage itself.

---
 rtl/hack_memory_map.sv | 144 ++++++++++++++
 tb/tb_hack_memory_map.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map.sv
// Hack data-memory decoder: turns the CPU data address and write strobe into
// one write enable per target (data RAM, IO0..IOF) and selects the read word.
// Purely combinational; reset only inhibits the write enables.
module hack_memory_map #(
  parameter logic [15:0] RAM_TOP    = 16'h0EFF,
  parameter logic [15:0] IO_LO_BASE = 16'h0800,
  parameter logic [15:0] IO_HI_BASE = 16'h1004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        load,
  output logic [15:0] out,
  output logic        loadRAM,
  output logic        loadIO0,
  output logic        loadIO1,
  output logic        loadIO2,
  output logic        loadIO3,
  output logic        loadIO4,
  output logic        loadIO5,
  output logic        loadIO6,
  output logic        loadIO7,
  output logic        loadIO8,
  output logic        loadIO9,
  output logic        loadIOA,
  output logic        loadIOB,
  output logic        loadIOC,
  output logic        loadIOD,
  output logic        loadIOE,
  output logic        loadIOF,
  input  logic [15:0] inRAM,
  input  logic [15:0] inIO0,
  input  logic [15:0] inIO1,
  input  logic [15:0] inIO2,
  input  logic [15:0] inIO3,
  input  logic [15:0] inIO4,
  input  logic [15:0] inIO5,
  input  logic [15:0] inIO6,
  input  logic [15:0] inIO7,
  input  logic [15:0] inIO8,
  input  logic [15:0] inIO9,
  input  logic [15:0] inIOA,
  input  logic [15:0] inIOB,
  input  logic [15:0] inIOC,
  input  logic [15:0] inIOD,
  input  logic [15:0] inIOE,
  input  logic [15:0] inIOF
);

  // The decode path never looks at the clock; it only reaches a sink here.
  logic unusedClk_s;
  assign unusedClk_s = clk;

  logic        ioHit_s;
  logic [3:0]  ioIdx_s;
  logic [15:0] loLocal_s;
  logic [15:0] hiLocal_s;
  logic [15:0] inIoArr_s [16];
  logic [15:0] loadIoVec_s;
  logic        ramWin_s;

  assign loLocal_s = address - IO_LO_BASE;
  assign hiLocal_s = address - IO_HI_BASE;

  assign inIoArr_s[0]  = inIO0;
  assign inIoArr_s[1]  = inIO1;
  assign inIoArr_s[2]  = inIO2;
  assign inIoArr_s[3]  = inIO3;
  assign inIoArr_s[4]  = inIO4;
  assign inIoArr_s[5]  = inIO5;
  assign inIoArr_s[6]  = inIO6;
  assign inIoArr_s[7]  = inIO7;
  assign inIoArr_s[8]  = inIO8;
  assign inIoArr_s[9]  = inIO9;
  assign inIoArr_s[10] = inIOA;
  assign inIoArr_s[11] = inIOB;
  assign inIoArr_s[12] = inIOC;
  assign inIoArr_s[13] = inIOD;
  assign inIoArr_s[14] = inIOE;
  assign inIoArr_s[15] = inIOF;

  // Locate the IO slot (if any) addressed: low window holds IO0..IO3, high window IO4..IOF.
  always_comb begin
    ioHit_s = 1'b0;
    ioIdx_s = 4'd0;
    if ((address >= IO_LO_BASE) && (address <= (IO_LO_BASE + 16'd3))) begin
      ioHit_s = 1'b1;
      ioIdx_s = loLocal_s[3:0];
    end else if ((address >= IO_HI_BASE) && (address <= (IO_HI_BASE + 16'd11))) begin
      ioHit_s = 1'b1;
      ioIdx_s = hiLocal_s[3:0] + 4'd4;
    end else begin
      ioHit_s = 1'b0;
      ioIdx_s = 4'd0;
    end
  end

  // Read mux: an IO slot wins, everything else (including unmapped holes) reads RAM.
  always_comb begin
    if (ioHit_s) begin
      out = inIoArr_s[ioIdx_s];
    end else begin
      out = inRAM;
    end
  end

  // RAM write window is unsigned and overlaps IO0..IO3, so RAM shadows those writes.
  assign ramWin_s = (address <= RAM_TOP);

  // Write enables, all held low while reset is asserted.
  always_comb begin
    loadIoVec_s = 16'h0000;
    loadRAM     = 1'b0;
    if (!reset && load) begin
      loadRAM = ramWin_s;
      if (ioHit_s) begin
        loadIoVec_s[ioIdx_s] = 1'b1;
      end else begin
        loadIoVec_s = 16'h0000;
      end
    end else begin
      loadIoVec_s = 16'h0000;
      loadRAM     = 1'b0;
    end
  end

  assign loadIO0 = loadIoVec_s[0];
  assign loadIO1 = loadIoVec_s[1];
  assign loadIO2 = loadIoVec_s[2];
  assign loadIO3 = loadIoVec_s[3];
  assign loadIO4 = loadIoVec_s[4];
  assign loadIO5 = loadIoVec_s[5];
  assign loadIO6 = loadIoVec_s[6];
  assign loadIO7 = loadIoVec_s[7];
  assign loadIO8 = loadIoVec_s[8];
  assign loadIO9 = loadIoVec_s[9];
  assign loadIOA = loadIoVec_s[10];
  assign loadIOB = loadIoVec_s[11];
  assign loadIOC = loadIoVec_s[12];
  assign loadIOD = loadIoVec_s[13];
  assign loadIOE = loadIoVec_s[14];
  assign loadIOF = loadIoVec_s[15];

endmodule

// File: tb/tb_hack_memory_map.sv
// Self-checking bench for hack_memory_map: directed table, address sweeps,
// randomized vectors against a behavioural map model, and a reset-release sequence.
module tb_hack_memory_map;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic        load;
  logic [15:0] inRam;
  logic [15:0] inIo [16];
  wire  [15:0] out;
  wire         loadRam;
  wire  [15:0] loadIo;

  int compared;
  int mismatched;

  hack_memory_map dut (
    .clk(clk), .reset(reset), .address(address), .load(load), .out(out),
    .loadRAM(loadRam),
    .loadIO0(loadIo[0]),   .loadIO1(loadIo[1]),   .loadIO2(loadIo[2]),   .loadIO3(loadIo[3]),
    .loadIO4(loadIo[4]),   .loadIO5(loadIo[5]),   .loadIO6(loadIo[6]),   .loadIO7(loadIo[7]),
    .loadIO8(loadIo[8]),   .loadIO9(loadIo[9]),   .loadIOA(loadIo[10]),  .loadIOB(loadIo[11]),
    .loadIOC(loadIo[12]),  .loadIOD(loadIo[13]),  .loadIOE(loadIo[14]),  .loadIOF(loadIo[15]),
    .inRAM(inRam),
    .inIO0(inIo[0]),   .inIO1(inIo[1]),   .inIO2(inIo[2]),   .inIO3(inIo[3]),
    .inIO4(inIo[4]),   .inIO5(inIo[5]),   .inIO6(inIo[6]),   .inIO7(inIo[7]),
    .inIO8(inIo[8]),   .inIO9(inIo[9]),   .inIOA(inIo[10]),  .inIOB(inIo[11]),
    .inIOC(inIo[12]),  .inIOD(inIo[13]),  .inIOE(inIo[14]),  .inIOF(inIo[15])
  );

  // Free-running clock; only the reset-release sequence uses its edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        ld;
    logic        rst;
    logic [15:0] expOut;
    logic [16:0] expLoads;   // {loadRAM, loadIOF..loadIO0}
  } vec_t;

  // Memory map from the address table: which IO slot an address names, or -1.
  function automatic int slotOf(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai >= 2048 && ai <= 2051) return ai - 2048;
    if (ai >= 4100 && ai <= 4111) return ai - 4096;
    return -1;
  endfunction

  function automatic void model(input logic [15:0] a, input logic ld, input logic rst,
                                output logic [15:0] eo, output logic [16:0] el);
    int s;
    s  = slotOf(a);
    eo = (s >= 0) ? inIo[s] : inRam;
    el = 17'h00000;
    if (!rst && ld) begin
      if (int'(a) <= 3839) el[16] = 1'b1;
      if (s >= 0) el[s] = 1'b1;
    end
  endfunction

  task automatic compare(input string name, input logic [15:0] a,
                         input logic [15:0] eo, input logic [16:0] el);
    compared++;
    if (out !== eo) begin
      mismatched++;
      $display("FAIL %s addr=%h: out=%h expected=%h", name, a, out, eo);
    end
    compared++;
    if ({loadRam, loadIo} !== el) begin
      mismatched++;
      $display("FAIL %s addr=%h: loads=%h expected=%h", name, a, {loadRam, loadIo}, el);
    end
  endtask

  task automatic applyModel(input string name, input logic [15:0] a,
                            input logic ld, input logic rst);
    logic [15:0] eo;
    logic [16:0] el;
    address = a; load = ld; reset = rst;
    #1;
    model(a, ld, rst, eo, el);
    compare(name, a, eo, el);
  endtask

  vec_t tbl [16];

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1; address = 16'h0000; load = 1'b0; inRam = 16'h1111;
    for (int k = 0; k < 16; k++) inIo[k] = 16'hA000 + 16'(k);

    // Directed table with hand-derived expectations (inRAM=1111, inIOk=A00k).
    tbl[0]  = '{16'd2050,  1'b1, 1'b0, 16'hA002, 17'h10004};
    tbl[1]  = '{16'd4100,  1'b1, 1'b0, 16'hA004, 17'h00010};
    tbl[2]  = '{16'd4111,  1'b1, 1'b0, 16'hA00F, 17'h08000};
    tbl[3]  = '{16'd3839,  1'b1, 1'b0, 16'h1111, 17'h10000};
    tbl[4]  = '{16'd3840,  1'b1, 1'b0, 16'h1111, 17'h00000};
    tbl[5]  = '{16'd4099,  1'b1, 1'b0, 16'h1111, 17'h00000};
    tbl[6]  = '{16'd4112,  1'b1, 1'b0, 16'h1111, 17'h00000};
    tbl[7]  = '{16'hFFFF,  1'b1, 1'b0, 16'h1111, 17'h00000};
    tbl[8]  = '{16'd2047,  1'b1, 1'b0, 16'h1111, 17'h10000};
    tbl[9]  = '{16'd2052,  1'b1, 1'b0, 16'h1111, 17'h10000};
    tbl[10] = '{16'd2049,  1'b1, 1'b1, 16'hA001, 17'h00000};
    tbl[11] = '{16'd2048,  1'b0, 1'b0, 16'hA000, 17'h00000};
    tbl[12] = '{16'd2051,  1'b1, 1'b0, 16'hA003, 17'h10008};
    tbl[13] = '{16'd0,     1'b1, 1'b0, 16'h1111, 17'h10000};
    tbl[14] = '{16'd4096,  1'b1, 1'b0, 16'h1111, 17'h00000};
    tbl[15] = '{16'd4105,  1'b0, 1'b1, 16'hA009, 17'h00000};

    // Reset state: all enables low even with a write to a dual-mapped slot.
    address = 16'd2048; load = 1'b1;
    #1;
    compare("reset_state", address, 16'hA000, 17'h00000);

    for (int i = 0; i < 16; i++) begin
      address = tbl[i].addr; load = tbl[i].ld; reset = tbl[i].rst;
      #1;
      compare($sformatf("table%0d", i), tbl[i].addr, tbl[i].expOut, tbl[i].expLoads);
    end

    // Distinct random IO read words for the sweeps.
    for (int k = 0; k < 16; k++) inIo[k] = 16'($urandom);
    inRam = 16'h1111;
    for (int ld = 0; ld < 2; ld++) begin
      for (int a = 2048; a <= 4111; a++) applyModel("sweep_io", 16'(a), 1'(ld), 1'b0);
    end

    // Low RAM region with a fresh RAM word each step.
    for (int a = 0; a <= 3839; a++) begin
      inRam = 16'($urandom);
      applyModel("sweep_ram", 16'(a), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Every IO slot read without a write.
    for (int k = 0; k < 16; k++) begin
      applyModel("io_noload", (k < 4) ? 16'(2048 + k) : 16'(4096 + k), 1'b0, 1'b0);
    end

    // Randomized addresses, strobes, reset and read data.
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] a;
      inRam = 16'($urandom);
      for (int k = 0; k < 16; k++) inIo[k] = 16'($urandom);
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(2040, 2060));
        1: a = 16'($urandom_range(3830, 4120));
        2: a = 16'($urandom_range(65500, 65535));
        default: a = 16'($urandom);
      endcase
      applyModel("random", a, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Reset release on a clock edge: enables follow immediately.
    inIo[1] = 16'h5A5A;
    inRam   = 16'h1111;
    @(posedge clk);
    reset = 1'b1; address = 16'd2049; load = 1'b1;
    #1;
    compare("held_reset", address, 16'h5A5A, 17'h00000);
    @(posedge clk);
    reset = 1'b0;
    #1;
    compare("reset_release", address, 16'h5A5A, 17'h10002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
